// File: rtl/untranspose_stream.sv
// Reassembles lane-parallel vectors from the row-serial stream of the transpose unit.
// Optional UNTRANSPOSE_PINGPONG_EN adds a second bank so one block fills while another drains.
module untranspose_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int LANES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DEPTH*WIDTH-1:0]   in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [LANES*WIDTH-1:0]   out_data,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);

  localparam int RW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(LANES - 1);
  localparam logic [VW-1:0] VEC_LAST = VW'(DEPTH - 1);

  logic                   run_q;
  logic [RW-1:0]          row_cnt_q, row_cnt_d;
  logic [VW-1:0]          vec_cnt_q, vec_cnt_d;
  logic [LANES*WIDTH-1:0] out_q, out_d;
  logic                   accept, handshake;

  assign out_data = out_q;

`ifdef UNTRANSPOSE_PINGPONG_EN

  logic [WIDTH-1:0] mem_q [2][DEPTH][LANES];
  logic [WIDTH-1:0] mem_d [2][DEPTH][LANES];
  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d, rbank_q, rbank_d;

  always_comb begin
    row_cnt_d = row_cnt_q;
    vec_cnt_d = vec_cnt_q;
    mem_d     = mem_q;
    out_d     = out_q;
    full_d    = full_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    in_ready  = run_q && !full_q[wbank_q];
    out_valid = full_q[rbank_q];
    out_last  = out_valid && (vec_cnt_q == VEC_LAST);
    busy      = (full_q != '0) || (row_cnt_q != '0);
    accept    = in_valid && in_ready;
    handshake = out_valid && out_ready;
    if (accept) begin
      for (int unsigned d = 0; d < DEPTH; d++)
        mem_d[wbank_q][d][row_cnt_q] = in_data[d*WIDTH +: WIDTH];
      if (row_cnt_q == ROW_LAST) begin
        row_cnt_d       = '0;
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
      end else begin
        row_cnt_d = row_cnt_q + RW'(1);
      end
    end
    // The filling bank is never the draining bank, so both updates can land together.
    if (handshake) begin
      if (vec_cnt_q == VEC_LAST) begin
        vec_cnt_d       = '0;
        full_d[rbank_q] = 1'b0;
        rbank_d         = !rbank_q;
      end else begin
        vec_cnt_d = vec_cnt_q + VW'(1);
      end
    end
    if (full_d[rbank_d]) begin
      for (int unsigned r = 0; r < LANES; r++)
        out_d[r*WIDTH +: WIDTH] = mem_d[rbank_d][vec_cnt_d][r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      row_cnt_q <= '0;
      vec_cnt_q <= '0;
      out_q     <= '0;
      full_q    <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned d = 0; d < DEPTH; d++)
          for (int unsigned r = 0; r < LANES; r++)
            mem_q[b][d][r] <= '0;
    end else begin
      run_q     <= 1'b1;
      row_cnt_q <= row_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      out_q     <= out_d;
      full_q    <= full_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      mem_q     <= mem_d;
    end
  end

`else

  typedef enum logic {FILL, DRAIN} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_q [DEPTH][LANES];
  logic [WIDTH-1:0] mem_d [DEPTH][LANES];

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    vec_cnt_d = vec_cnt_q;
    mem_d     = mem_q;
    out_d     = out_q;
    in_ready  = run_q && (state_q == FILL);
    out_valid = (state_q == DRAIN);
    out_last  = out_valid && (vec_cnt_q == VEC_LAST);
    busy      = (state_q == DRAIN) || (row_cnt_q != '0);
    accept    = in_valid && in_ready;
    handshake = out_valid && out_ready;
    if (accept) begin
      for (int unsigned d = 0; d < DEPTH; d++)
        mem_d[d][row_cnt_q] = in_data[d*WIDTH +: WIDTH];
      if (row_cnt_q == ROW_LAST) begin
        row_cnt_d = '0;
        state_d   = DRAIN;
      end else begin
        row_cnt_d = row_cnt_q + RW'(1);
      end
    end
    if (handshake) begin
      if (vec_cnt_q == VEC_LAST) begin
        vec_cnt_d = '0;
        state_d   = FILL;
      end else begin
        vec_cnt_d = vec_cnt_q + VW'(1);
      end
    end
    // Load from the post-write image so the last row reaches vector 0 without a bubble.
    if (state_d == DRAIN) begin
      for (int unsigned r = 0; r < LANES; r++)
        out_d[r*WIDTH +: WIDTH] = mem_d[vec_cnt_d][r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      run_q     <= 1'b0;
      row_cnt_q <= '0;
      vec_cnt_q <= '0;
      out_q     <= '0;
      for (int unsigned d = 0; d < DEPTH; d++)
        for (int unsigned r = 0; r < LANES; r++)
          mem_q[d][r] <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      row_cnt_q <= row_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      out_q     <= out_d;
      mem_q     <= mem_d;
    end
  end

`endif

endmodule
